// File: rtl/taxi_eth_link_led_pkg.sv
// Shared types and helpers for the Ethernet link/activity LED controller.
package taxi_eth_link_led_pkg;

  typedef enum logic [1:0] {
    DOWN     = 2'd0,
    DEBOUNCE = 2'd1,
    UP       = 2'd2
  } link_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/taxi_eth_link_led_ch.sv
// One channel: link FSM with debounce, activity/error LED holds and a flap counter.
module taxi_eth_link_led_ch
  import taxi_eth_link_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned ACT_TICKS      = 4,
  parameter int unsigned ERR_TICKS      = 64,
  parameter int unsigned FLAP_W         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_status,
  input  logic              i_act_evt,
  input  logic              i_tick,
  input  logic              i_blink,
  input  logic              i_flap_clr,
  output logic              o_link_up,
  output logic [FLAP_W-1:0] o_flap_cnt,
  output logic              o_led_g,
  output logic              o_led_r
);

  localparam int unsigned DebW = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned ActW = cnt_width(ACT_TICKS);
  localparam int unsigned ErrW = cnt_width(ERR_TICKS);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_TICKS);
  localparam logic [ActW-1:0] ActMax = ActW'(ACT_TICKS);
  localparam logic [ErrW-1:0] ErrMax = ErrW'(ERR_TICKS);

  link_state_t       r_state, w_state_d;
  logic [DebW-1:0]   r_deb, w_deb_d;
  logic [ActW-1:0]   r_act, w_act_d;
  logic [ErrW-1:0]   r_err, w_err_d;
  logic [FLAP_W-1:0] r_flap, w_flap_d;
  logic              w_drop;
  logic              w_led_g;
  logic              r_link_up, r_led_g, r_led_r;

  always_comb begin
    w_state_d = r_state;
    w_deb_d   = r_deb;
    w_drop    = 1'b0;
    unique case (r_state)
      DOWN: begin
        if (i_status) begin
          w_state_d = DEBOUNCE;
          w_deb_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!i_status) begin
          w_state_d = DOWN;
        end else if (i_tick) begin
          w_deb_d = r_deb + 1'b1;
          if (w_deb_d == DebMax) w_state_d = UP;
        end
      end
      UP: begin
        if (!i_status) begin
          w_state_d = DOWN;
          w_drop    = 1'b1;
        end
      end
      default: w_state_d = DOWN;
    endcase
  end

  // Loads take priority over a coincident tick decrement.
  always_comb begin
    w_err_d = r_err;
    if (w_drop) begin
      w_err_d = ErrMax;
    end else if (i_tick && (r_err != '0)) begin
      w_err_d = r_err - 1'b1;
    end

    w_act_d = r_act;
    if ((r_state != UP) || w_drop) begin
      w_act_d = '0;
    end else if (i_act_evt) begin
      w_act_d = ActMax;
    end else if (i_tick && (r_act != '0)) begin
      w_act_d = r_act - 1'b1;
    end

    w_flap_d = r_flap;
    if (i_flap_clr) begin
      w_flap_d = '0;
    end else if (w_drop && (r_flap != '1)) begin
      w_flap_d = r_flap + 1'b1;
    end

    w_led_g = 1'b0;
    if (r_state == UP) begin
      w_led_g = (w_act_d == '0);
    end else if (r_state == DEBOUNCE) begin
      w_led_g = i_blink;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= DOWN;
      r_deb     <= '0;
      r_act     <= '0;
      r_err     <= '0;
      r_flap    <= '0;
      r_link_up <= 1'b0;
      r_led_g   <= 1'b0;
      r_led_r   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_deb     <= w_deb_d;
      r_act     <= w_act_d;
      r_err     <= w_err_d;
      r_flap    <= w_flap_d;
      r_link_up <= (r_state == UP);
      r_led_g   <= w_led_g;
      r_led_r   <= (r_err != '0);
    end
  end

  assign o_link_up  = r_link_up;
  assign o_flap_cnt = r_flap;
  assign o_led_g    = r_led_g;
  assign o_led_r    = r_led_r;

endmodule

// File: rtl/taxi_sync_signal.sv
// Multi-stage synchroniser for asynchronous level signals; flops clear on reset.
module taxi_sync_signal #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [N-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], in};
    end
  end

  assign out = r_sync[N-1];

endmodule

// File: rtl/taxi_eth_link_led_ctrl.sv
// Multi-channel Ethernet link/activity LED controller: synchronisers, shared tick
// and blink timebase, and one independent channel instance per port.
module taxi_eth_link_led_ctrl
  import taxi_eth_link_led_pkg::*;
#(
  parameter int unsigned CNT            = 8,
  parameter int unsigned PRESCALE       = 15625,
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned ACT_TICKS      = 4,
  parameter int unsigned ERR_TICKS      = 64,
  parameter int unsigned BLINK_TICKS    = 32,
  parameter int unsigned FLAP_W         = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CNT-1:0]             i_rx_status,
  input  logic [CNT-1:0]             i_rx_act_toggle,
  input  logic [CNT-1:0]             i_flap_clr,
  output logic [CNT-1:0]             o_link_up,
  output logic [CNT-1:0][FLAP_W-1:0] o_flap_cnt,
  output logic [CNT-1:0]             o_led_g,
  output logic [CNT-1:0]             o_led_r
);

  localparam int unsigned PreW = cnt_width(PRESCALE - 1);
  localparam int unsigned BlkW = cnt_width(BLINK_TICKS - 1);
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_TICKS - 1);

  logic [CNT-1:0]  w_status_sync, w_act_sync, w_act_evt;
  logic [CNT-1:0]  r_act_prev;
  logic [PreW-1:0] r_prescale;
  logic            r_tick;
  logic [BlkW-1:0] r_blink_cnt;
  logic            r_blink;

  taxi_sync_signal #(
    .WIDTH (CNT),
    .N     (SYNC_STAGES)
  ) u_sync_status (
    .clk (i_clk),
    .rst (i_rst),
    .in  (i_rx_status),
    .out (w_status_sync)
  );

  taxi_sync_signal #(
    .WIDTH (CNT),
    .N     (SYNC_STAGES)
  ) u_sync_act (
    .clk (i_clk),
    .rst (i_rst),
    .in  (i_rx_act_toggle),
    .out (w_act_sync)
  );

  assign w_act_evt = w_act_sync ^ r_act_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_act_prev  <= '0;
      r_prescale  <= '0;
      r_tick      <= 1'b0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_act_prev <= w_act_sync;
      r_tick     <= (r_prescale == PreMax);
      r_prescale <= (r_prescale == PreMax) ? '0 : r_prescale + 1'b1;
      if (r_tick) begin
        if (r_blink_cnt == BlkMax) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CNT; g++) begin : g_ch
    taxi_eth_link_led_ch #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .ACT_TICKS      (ACT_TICKS),
      .ERR_TICKS      (ERR_TICKS),
      .FLAP_W         (FLAP_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_status   (w_status_sync[g]),
      .i_act_evt  (w_act_evt[g]),
      .i_tick     (r_tick),
      .i_blink    (r_blink),
      .i_flap_clr (i_flap_clr[g]),
      .o_link_up  (o_link_up[g]),
      .o_flap_cnt (o_flap_cnt[g]),
      .o_led_g    (o_led_g[g]),
      .o_led_r    (o_led_r[g])
    );
  end

endmodule
